// File: rtl/uart_axil_cmd.sv
// uart_axil_cmd
//   Host command decoder sitting between uart_rx/uart_tx and the AXI4-Lite
//   interconnect. A frame is a command byte (0x40 write, 0x80 read), then a
//   32-bit address, then 32-bit write data for writes. All multi-byte fields
//   are sent LSB first. Each frame runs one AXI4-Lite transaction. The block
//   answers with read data (reads only) and one status byte.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   rx_valid/rx_data     received byte strobe and byte
//   rx_err               framing-error strobe; aborts a partial frame
//   tx_act/tx_data       start strobe and byte for uart_tx
//   tx_busy              uart_tx busy flag
//   m_aw*/m_w*/m_b*      AXI4-Lite write address/data/response channels
//   m_ar*/m_r*           AXI4-Lite read address/data channels
module uart_axil_cmd #(
  parameter int unsigned BYTE_TIMEOUT = 2_000_000,
  parameter int unsigned AXI_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic        tx_act,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam int unsigned GAP_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned TMR_W = $clog2(AXI_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AXI_TIMEOUT - 1);

  localparam logic [7:0] CMD_WR     = 8'h40;
  localparam logic [7:0] CMD_RD     = 8'h80;
  localparam logic [7:0] ST_TIMEOUT = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_AW_W,
    S_B,
    S_AR,
    S_R,
    S_TX_START,   // wait for uart_tx idle, then strobe the next byte
    S_TX_HI,      // wait for tx_busy to rise
    S_TX_LO       // wait for tx_busy to fall
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  // Response bytes, LSB first: {status, rdata} for reads, {.., status} otherwise
  logic [39:0]       txsr_q, txsr_d;
  logic [2:0]        txn_q, txn_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_act_q, tx_act_d;

  logic              rx_ok;
  logic              aw_hs, w_hs;
  logic              aw_fin, w_fin;
  logic              abort_axi;

  // A byte that arrives together with a framing error is treated as lost.
  assign rx_ok = rx_valid & ~rx_err;

  assign m_awvalid = (state_q == S_AW_W) & ~aw_done_q;
  assign m_wvalid  = (state_q == S_AW_W) & ~w_done_q;
  assign m_bready  = (state_q == S_B);
  assign m_arvalid = (state_q == S_AR);
  assign m_rready  = (state_q == S_R);

  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = 4'hF;
  assign m_awprot  = '0;
  assign m_arprot  = '0;

  assign tx_act    = tx_act_q;
  assign tx_data   = tx_data_q;

  assign aw_hs  = m_awvalid & m_awready;
  assign w_hs   = m_wvalid & m_wready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gap_d     = gap_q;
    tmr_d     = tmr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    txsr_d    = txsr_q;
    txn_d     = txn_q;
    tx_data_d = tx_data_q;
    tx_act_d  = 1'b0;
    abort_axi = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        gap_d = '0;
        if (rx_ok && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
          is_wr_d = (rx_data == CMD_WR);
          state_d = S_ADDR;
        end
      end

      S_ADDR, S_DATA: begin
        if (rx_err) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          gap_d = '0;
          cnt_d = cnt_q + 1'b1;
          if (state_q == S_ADDR) begin
            addr_d = {rx_data, addr_q[31:8]};
          end else begin
            wdata_d = {rx_data, wdata_q[31:8]};
          end
          if (cnt_q == 2'd3) begin
            tmr_d     = '0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (state_q == S_DATA) begin
              state_d = S_AW_W;
            end else begin
              state_d = is_wr_q ? S_DATA : S_AR;
            end
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_AW_W: begin
        if (aw_fin && w_fin) begin
          tmr_d   = '0;
          state_d = S_B;
        end else if (tmr_q == TMR_LAST) begin
          abort_axi = 1'b1;
        end else begin
          tmr_d     = tmr_q + 1'b1;
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end

      S_B: begin
        if (m_bvalid) begin
          txsr_d  = {32'h0, 6'b0, m_bresp};
          txn_d   = 3'd1;
          state_d = S_TX_START;
        end else if (tmr_q == TMR_LAST) begin
          abort_axi = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_AR: begin
        if (m_arready) begin
          tmr_d   = '0;
          state_d = S_R;
        end else if (tmr_q == TMR_LAST) begin
          abort_axi = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_R: begin
        if (m_rvalid) begin
          txsr_d  = {6'b0, m_rresp, m_rdata};
          txn_d   = 3'd5;
          state_d = S_TX_START;
        end else if (tmr_q == TMR_LAST) begin
          abort_axi = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_TX_START: begin
        if (!tx_busy) begin
          tx_data_d = txsr_q[7:0];
          tx_act_d  = 1'b1;
          state_d   = S_TX_HI;
        end
      end

      S_TX_HI: begin
        if (tx_busy) begin
          state_d = S_TX_LO;
        end
      end

      S_TX_LO: begin
        if (!tx_busy) begin
          txsr_d  = {8'h00, txsr_q[39:8]};
          txn_d   = txn_q - 1'b1;
          state_d = (txn_q == 3'd1) ? S_IDLE : S_TX_START;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Leaving the wait state drops every valid/ready; only 0xFF is reported.
    if (abort_axi) begin
      txsr_d  = {32'h0, ST_TIMEOUT};
      txn_d   = 3'd1;
      state_d = S_TX_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gap_q     <= '0;
      tmr_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      txsr_q    <= '0;
      txn_q     <= '0;
      tx_data_q <= '0;
      tx_act_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gap_q     <= gap_d;
      tmr_q     <= tmr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      txsr_q    <= txsr_d;
      txn_q     <= txn_d;
      tx_data_q <= tx_data_d;
      tx_act_q  <= tx_act_d;
    end
  end

endmodule

// File: tb/tb_uart_axil_cmd.sv
// Testbench for uart_axil_cmd: a simple uart_tx stand-in, a configurable
// AXI4-Lite slave with a 16-word memory, a directed vector table, hand
// sequences for aborts and reset, and random frames against a reference model.
module tb_uart_axil_cmd;

  localparam int unsigned BT = 64;
  localparam int unsigned AT = 32;
  localparam logic [31:0] RD_DFLT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_err;
  logic [7:0]  rx_data;
  logic        tx_act, tx_busy;
  logic [7:0]  tx_data;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_bvalid = 1'b0, m_bready;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_arvalid, m_arready;
  logic        m_rvalid = 1'b0, m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;

  uart_axil_cmd #(.BYTE_TIMEOUT(BT), .AXI_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .tx_act(tx_act), .tx_data(tx_data), .tx_busy(tx_busy),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // ---------------- uart_tx stand-in ----------------
  int unsigned busy_cnt = 0;
  logic [7:0]  txq[$];
  logic [7:0]  last_tx = '0;
  int unsigned tx_glitch = 0;
  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_act) begin
      txq.push_back(tx_data);
      last_tx  <= tx_data;
      busy_cnt <= 8;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (tx_busy && !tx_act && tx_data !== last_tx) tx_glitch <= tx_glitch + 1;
  end

  // ---------------- AXI4-Lite slave ----------------
  int unsigned cfg_awd = 0, cfg_wd = 0;
  logic        cfg_ar_en = 1'b1;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int unsigned aw_wait = 0, w_wait = 0;
  logic        got_aw = 1'b0, got_w = 1'b0;
  logic [3:0]  aw_idx = '0;
  logic [31:0] w_dat = '0;
  logic [31:0] mem [16];
  logic        mem_v [16] = '{default: 1'b0};
  logic [31:0] aw_log [256];
  logic [35:0] w_log [256];
  int unsigned aw_cnt = 0, w_cnt = 0, ar_vcyc = 0, drops = 0;
  logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [31:0] aw_held = '0, w_held = '0, ar_held = '0;

  assign m_awready = m_awvalid && (aw_wait >= cfg_awd);
  assign m_wready  = m_wvalid && (w_wait >= cfg_wd);
  assign m_arready = m_arvalid && cfg_ar_en;

  always @(posedge clk) begin
    if (m_awvalid && m_awready) begin
      aw_log[aw_cnt[7:0]] <= m_awaddr;
      aw_cnt <= aw_cnt + 1;
      got_aw <= 1'b1;
      aw_idx <= m_awaddr[5:2];
      aw_wait <= 0;
    end else if (m_awvalid) aw_wait <= aw_wait + 1;
    else aw_wait <= 0;

    if (m_wvalid && m_wready) begin
      w_log[w_cnt[7:0]] <= {m_wstrb, m_wdata};
      w_cnt <= w_cnt + 1;
      got_w <= 1'b1;
      w_dat <= m_wdata;
      w_wait <= 0;
    end else if (m_wvalid) w_wait <= w_wait + 1;
    else w_wait <= 0;

    if (got_aw && got_w && !m_bvalid) begin
      mem[aw_idx]   <= w_dat;
      mem_v[aw_idx] <= 1'b1;
      m_bvalid      <= 1'b1;
      m_bresp       <= cfg_bresp;
      got_aw        <= 1'b0;
      got_w         <= 1'b0;
    end else if (m_bvalid && m_bready) m_bvalid <= 1'b0;

    if (m_arvalid) ar_vcyc <= ar_vcyc + 1;
    if (m_arvalid && m_arready) begin
      m_rvalid <= 1'b1;
      m_rdata  <= mem_v[m_araddr[5:2]] ? mem[m_araddr[5:2]] : RD_DFLT;
      m_rresp  <= cfg_rresp;
    end else if (m_rvalid && m_rready) m_rvalid <= 1'b0;

    // a valid must stay up with a stable payload until its handshake
    aw_pend <= m_awvalid && !m_awready;  aw_held <= m_awaddr;
    w_pend  <= m_wvalid && !m_wready;    w_held  <= m_wdata;
    ar_pend <= m_arvalid && !m_arready;  ar_held <= m_araddr;
    if ((aw_pend && (!m_awvalid || m_awaddr !== aw_held)) ||
        (w_pend  && (!m_wvalid  || m_wdata  !== w_held))  ||
        (ar_pend && (!m_arvalid || m_araddr !== ar_held)))
      drops <= drops + 1;

    if (rst) begin
      m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      got_aw <= 1'b0; got_w <= 1'b0;
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];
  logic        ref_v [16] = '{default: 1'b0};

  function automatic logic [39:0] model_read(input logic [31:0] a, input logic [1:0] rr);
    logic [31:0] v;
    v = ref_v[a[5:2]] ? ref_mem[a[5:2]] : RD_DFLT;
    return {6'b0, rr, v};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_err();
    @(negedge clk); rx_err = 1'b1;
    @(negedge clk); rx_err = 1'b0;
  endtask

  task automatic set_cfg(input int unsigned awd, input int unsigned wd, input logic ar_en,
                         input logic [1:0] br, input logic [1:0] rr);
    cfg_awd = awd; cfg_wd = wd; cfg_ar_en = ar_en; cfg_bresp = br; cfg_rresp = rr;
  endtask

  task automatic run_frame(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input int unsigned gap, input int unsigned n,
                           input logic [39:0] exp, input logic exp_wr, input logic to);
    int unsigned q0, aw0, w0, ar0, dr0, cyc;
    logic [39:0] e;
    q0 = txq.size(); aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_vcyc; dr0 = drops;
    send_byte(wr ? 8'h40 : 8'h80, gap);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], (!wr && i == 3) ? 0 : gap);
    if (wr) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], (i == 3) ? 0 : gap);
    // first cycle after the last frame byte
    if (wr) check({name, " valid timing"}, {62'h0, m_awvalid, m_wvalid}, 64'h3);
    else    check({name, " valid timing"}, {63'h0, m_arvalid}, 64'h1);
    cyc = 0;
    while (!(txq.size() >= q0 + n && !tx_busy) && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    check({name, " response within budget"}, {63'h0, cyc < 3000}, 64'h1);
    repeat (6) @(negedge clk);
    check({name, " tx byte count"}, 64'(txq.size() - q0), 64'(n));
    e = exp;
    for (int i = 0; i < 5; i++) begin
      if (i < n && q0 + i < txq.size()) check({name, " tx byte"}, {56'h0, txq[q0+i]}, {56'h0, e[7:0]});
      e = e >> 8;
    end
    check({name, " aw count"}, 64'(aw_cnt - aw0), {63'h0, exp_wr});
    check({name, " w count"}, 64'(w_cnt - w0), {63'h0, exp_wr});
    if (exp_wr && aw_cnt > aw0 && w_cnt > w0) begin
      check({name, " awaddr"}, {32'h0, aw_log[aw0[7:0]]}, {32'h0, addr});
      check({name, " wstrb/wdata"}, {28'h0, w_log[w0[7:0]]}, {28'h0, 4'hF, data});
    end
    if (!wr) check({name, " arvalid cycles"}, 64'(ar_vcyc - ar0), to ? 64'(AT) : 64'd1);
    if (!to) check({name, " valid held to handshake"}, 64'(drops - dr0), 64'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned awd;
    int unsigned wd;
    logic        ar_en;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    int unsigned n;
    logic [39:0] exp;
    logic        exp_wr;
    logic        to;
  } vec_t;

  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    logic        wr;
    logic [31:0] a, d;
    logic [1:0]  br, rr;
    logic [7:0]  junk;
    int unsigned q0, aw0, cyc;

    rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    check("reset tx_act", {63'h0, tx_act}, 64'h0);
    check("reset valid/ready", {59'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'h0);
    check("reset tx_data", {56'h0, tx_data}, 64'h0);
    check("reset addr/data", {m_awaddr ^ m_araddr, m_wdata | m_araddr}, 64'h0);
    check("wstrb/prot", {56'h0, m_wstrb, 1'b0, m_awprot | m_arprot}, {56'h0, 4'hF, 4'h0});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    //         wr    addr          data          awd wd  ar    br     rr     n  exp                  wr    to
    vt[0] = '{1'b1, 32'h4000_0008, 32'h0000_0003, 0,  0, 1'b1, 2'b00, 2'b00, 1, 40'h00,             1'b1, 1'b0};
    vt[1] = '{1'b0, 32'h4000_0000, 32'h0,         0,  0, 1'b1, 2'b00, 2'b00, 5, 40'h00_DEAD_BEEF,   1'b0, 1'b0};
    vt[2] = '{1'b1, 32'h4000_0010, 32'hA5A5_1234, 5,  1, 1'b1, 2'b00, 2'b00, 1, 40'h00,             1'b1, 1'b0};
    vt[3] = '{1'b0, 32'h4000_0008, 32'h0,         0,  0, 1'b1, 2'b00, 2'b10, 5, 40'h02_0000_0003,   1'b0, 1'b0};
    vt[4] = '{1'b1, 32'h4000_0014, 32'h0BAD_F00D, 2,  3, 1'b1, 2'b10, 2'b00, 1, 40'h02,             1'b1, 1'b0};
    vt[5] = '{1'b0, 32'h4000_0000, 32'h0,         0,  0, 1'b0, 2'b00, 2'b00, 1, 40'hFF,             1'b0, 1'b1};
    vt[6] = '{1'b1, 32'h4000_0018, 32'h0000_0001, 999, 999, 1'b1, 2'b00, 2'b00, 1, 40'hFF,          1'b0, 1'b1};
    vt[7] = '{1'b0, 32'h4000_0014, 32'h0,         0,  0, 1'b1, 2'b00, 2'b01, 5, 40'h01_0BAD_F00D,   1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      set_cfg(vt[v].awd, vt[v].wd, vt[v].ar_en, vt[v].bresp, vt[v].rresp);
      run_frame($sformatf("vec%0d", v), vt[v].wr, vt[v].addr, vt[v].data, 1,
                vt[v].n, vt[v].exp, vt[v].exp_wr, vt[v].to);
      if (vt[v].exp_wr) begin
        ref_mem[vt[v].addr[5:2]] = vt[v].data;
        ref_v[vt[v].addr[5:2]]   = 1'b1;
      end
    end
    set_cfg(0, 0, 1'b1, 2'b00, 2'b00);

    // rx_err mid-address: partial write dropped, then a read works
    aw0 = aw_cnt;
    send_byte(8'h40, 1);
    for (int i = 0; i < 3; i++) send_byte(8'h11 * (i + 1), 1);
    pulse_err();
    run_frame("after rx_err", 1'b0, 32'h4000_0008, 32'h0, 1, 5, model_read(32'h4000_0008, 2'b00), 1'b0, 1'b0);
    check("abort no aw", 64'(aw_cnt - aw0), 64'd0);

    // inter-byte silence past BYTE_TIMEOUT drops the partial frame
    send_byte(8'h80, 1);
    send_byte(8'h10, 1);
    send_byte(8'h00, BT + 10);
    run_frame("after gap abort", 1'b0, 32'h4000_0010, 32'h0, 1, 5, model_read(32'h4000_0010, 2'b00), 1'b0, 1'b0);

    // gaps just under the limit keep the frame alive
    run_frame("slow frame", 1'b1, 32'h4000_001C, 32'h7654_3210, BT - 8, 1, 40'h00, 1'b1, 1'b0);
    ref_mem[7] = 32'h7654_3210; ref_v[7] = 1'b1;

    // command byte coinciding with rx_err is lost
    @(negedge clk); rx_valid = 1'b1; rx_err = 1'b1; rx_data = 8'h80;
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b0;
    run_frame("err+valid", 1'b1, 32'h4000_0020, 32'h1357_9BDF, 1, 1, 40'h00, 1'b1, 1'b0);
    ref_mem[8] = 32'h1357_9BDF; ref_v[8] = 1'b1;

    // random frames against the model
    for (int k = 0; k < 40; k++) begin
      wr = $urandom_range(0, 1) == 1;
      a  = 32'h4000_0000 + 32'($urandom_range(0, 15)) * 4;
      d  = $urandom;
      br = 2'($urandom_range(0, 3));
      rr = 2'($urandom_range(0, 3));
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, br, rr);
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h40 || junk == 8'h80) junk = 8'h5A;
        send_byte(junk, 1);
      end
      if (wr) begin
        run_frame($sformatf("rand%0d wr", k), 1'b1, a, d, $urandom_range(0, 2), 1, {38'h0, br}, 1'b1, 1'b0);
        ref_mem[a[5:2]] = d; ref_v[a[5:2]] = 1'b1;
      end else begin
        run_frame($sformatf("rand%0d rd", k), 1'b0, a, 32'h0, $urandom_range(0, 2), 5, model_read(a, rr), 1'b0, 1'b0);
      end
    end
    check("tx_data stable while busy", 64'(tx_glitch), 64'd0);

    // reset just before the second response byte would start
    set_cfg(0, 0, 1'b1, 2'b00, 2'b00);
    q0 = txq.size();
    send_byte(8'h80, 1);
    for (int i = 0; i < 4; i++) send_byte(i == 3 ? 8'h40 : 8'h00, i == 3 ? 0 : 1);
    cyc = 0;
    while (!(txq.size() >= q0 + 1 && !tx_busy) && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    check("reset test first byte", {63'h0, cyc < 3000}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst clears tx_act", {63'h0, tx_act}, 64'h0);
    check("rst clears tx_data/araddr", {24'h0, tx_data, m_araddr}, 64'h0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("no bytes after reset", 64'(txq.size() - q0), 64'd1);
    run_frame("after reset", 1'b0, 32'h4000_0004, 32'h0, 1, 5, model_read(32'h4000_0004, 2'b00), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
